// File: rtl/usb_rx_pkg.sv
// Shared USB receive definitions: line idle level, default stuffing run length
// and the per-strobe bit classification used by the NRZI decoder.
package usb_rx_pkg;

    localparam logic USB_IDLE_LEVEL    = 1'b1;
    localparam int   DEFAULT_STUFF_LEN = 6;

    typedef enum logic [2:0] {
        BIT_NONE,
        BIT_ACCEPT,
        BIT_STUFF,
        BIT_STUFF_ERR,
        BIT_EOP
    } bit_action_e;

    // clear behaves like an end-of-packet even without a strobe and wins over everything
    function automatic bit_action_e classify_bit(
        input logic strobe,
        input logic eop,
        input logic clear,
        input logic stuff_slot,
        input logic d
    );
        if (clear || (strobe && eop)) return BIT_EOP;
        if (!strobe)                  return BIT_NONE;
        if (!stuff_slot)              return BIT_ACCEPT;
        if (d)                        return BIT_STUFF_ERR;
        return BIT_STUFF;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level, with a
// configurable reset value so an idle line does not glitch out of reset.
module sync_chain #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_in,
    output logic d_sync
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign d_sync = sync_q[STAGES-1];

endmodule

// File: rtl/nrzi_rx_decoder.sv
// USB-style receive front end: synchronises the NRZI line, decodes it, strips
// stuffed zeros, flags stuffing violations and deserialises LSB-first words.
module nrzi_rx_decoder
    import usb_rx_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int STUFF_LEN   = DEFAULT_STUFF_LEN,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              dp_in,
    input  logic              shift_enable,
    input  logic              eop,
    input  logic              clear,
    output logic              d_orig,
    output logic              bit_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              data_valid,
    output logic              stuff_err
);

    localparam int OC_W = $clog2(STUFF_LEN + 1);
    localparam int BC_W = $clog2(DATA_W);
    // The shifter only needs the first DATA_W-1 bits; the final bit joins them on completion.
    localparam int SR_W = DATA_W - 1;

    localparam logic [OC_W-1:0] STUFF_AT = OC_W'(STUFF_LEN);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    logic              dp_s;
    logic              prev_level_q, prev_level_d;
    logic [OC_W-1:0]   ones_cnt_q, ones_cnt_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              data_valid_q, data_valid_d;
    logic              stuff_err_q, stuff_err_d;
    logic              stuff_slot;
    bit_action_e       action;

    sync_chain #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (USB_IDLE_LEVEL)
    ) u_sync (
        .clk    (clk),
        .n_rst  (n_rst),
        .d_in   (dp_in),
        .d_sync (dp_s)
    );

    assign d_orig     = ~(dp_s ^ prev_level_q);
    assign stuff_slot = (ones_cnt_q == STUFF_AT);
    assign action     = classify_bit(shift_enable, eop, clear, stuff_slot, d_orig);
    assign bit_valid  = (action == BIT_ACCEPT);

    always_comb begin
        prev_level_d = prev_level_q;
        ones_cnt_d   = ones_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        sr_d         = sr_q;
        rx_data_d    = rx_data_q;
        data_valid_d = 1'b0;
        stuff_err_d  = 1'b0;

        case (action)
            BIT_EOP: begin
                prev_level_d = USB_IDLE_LEVEL;
                ones_cnt_d   = '0;
                bit_cnt_d    = '0;
                sr_d         = '0;
            end
            BIT_ACCEPT: begin
                prev_level_d = dp_s;
                ones_cnt_d   = d_orig ? ones_cnt_q + 1'b1 : '0;
                sr_d         = SR_W'({d_orig, sr_q} >> 1);
                if (bit_cnt_q == LAST_BIT) begin
                    rx_data_d    = {d_orig, sr_q};
                    data_valid_d = 1'b1;
                    bit_cnt_d    = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            BIT_STUFF: begin
                prev_level_d = dp_s;
                ones_cnt_d   = '0;
            end
            BIT_STUFF_ERR: begin
                prev_level_d = dp_s;
                ones_cnt_d   = '0;
                stuff_err_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_level_q <= USB_IDLE_LEVEL;
            ones_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            sr_q         <= '0;
            rx_data_q    <= '0;
            data_valid_q <= 1'b0;
            stuff_err_q  <= 1'b0;
        end else begin
            prev_level_q <= prev_level_d;
            ones_cnt_q   <= ones_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            sr_q         <= sr_d;
            rx_data_q    <= rx_data_d;
            data_valid_q <= data_valid_d;
            stuff_err_q  <= stuff_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign data_valid = data_valid_q;
    assign stuff_err  = stuff_err_q;

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Directed bench for nrzi_rx_decoder: NRZI-encodes hand-picked words on the
// line, strobes once every 8 clocks and checks decode, stuffing and reset.
module tb_nrzi_rx_decoder;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       dp_in;
    logic       shift_enable;
    logic       eop;
    logic       clear;
    logic       d_orig;
    logic       bit_valid;
    logic [7:0] rx_data;
    logic       data_valid;
    logic       stuff_err;

    int tests = 0;
    int fails = 0;
    int dv_cnt = 0;
    int se_cnt = 0;
    int exp_dv = 0;
    int exp_se = 0;

    logic line;
    logic obs_d, obs_v;

    nrzi_rx_decoder #(
        .DATA_W      (8),
        .STUFF_LEN   (6),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .dp_in        (dp_in),
        .shift_enable (shift_enable),
        .eop          (eop),
        .clear        (clear),
        .d_orig       (d_orig),
        .bit_valid    (bit_valid),
        .rx_data      (rx_data),
        .data_valid   (data_valid),
        .stuff_err    (stuff_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) dv_cnt <= dv_cnt + 1;
        if (stuff_err)  se_cnt <= se_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Put a level on the line, let it settle through the synchroniser, then strobe once.
    task automatic strobe_level(input logic lvl, input logic e, output logic od, output logic ov);
        @(negedge clk);
        dp_in = lvl;
        repeat (6) @(negedge clk);
        shift_enable = 1'b1;
        eop          = e;
        #1;
        od = d_orig;
        ov = bit_valid;
        @(negedge clk);
        shift_enable = 1'b0;
        eop          = 1'b0;
    endtask

    task automatic send_bit(input logic b, input string tag);
        if (!b) line = ~line;
        strobe_level(line, 1'b0, obs_d, obs_v);
        check({tag, "_dorig"}, 32'(obs_d), 32'(b));
        check({tag, "_valid"}, 32'(obs_v), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] v, input string tag);
        for (int i = 0; i < 8; i++) send_bit(v[i], tag);
    endtask

    task automatic send_eop(input string tag);
        line = 1'b1;
        strobe_level(1'b1, 1'b1, obs_d, obs_v);
        check({tag, "_eop_valid"}, 32'(obs_v), 32'd0);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        n_rst        = 1'b0;
        dp_in        = 1'b1;
        shift_enable = 1'b0;
        eop          = 1'b0;
        clear        = 1'b0;
        line         = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dorig", 32'(d_orig), 32'd1);
        check("rst_valid", 32'(bit_valid), 32'd0);
        check("rst_rxdata", 32'(rx_data), 32'h00);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_se", 32'(stuff_err), 32'd0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_dorig", 32'(d_orig), 32'd1);
        check("post_rst_valid", 32'(bit_valid), 32'd0);

        // Plain word
        send_byte(8'hA5, "a5");
        settle();
        exp_dv++;
        check("a5_rxdata", 32'(rx_data), 32'hA5);
        check("a5_dvcnt", 32'(dv_cnt), 32'(exp_dv));
        send_eop("a5");

        // All-ones word with a stuffed zero after the sixth one
        for (int i = 0; i < 6; i++) send_bit(1'b1, "ff");
        line = ~line;
        strobe_level(line, 1'b0, obs_d, obs_v);
        check("ff_stuff_dorig", 32'(obs_d), 32'd0);
        check("ff_stuff_valid", 32'(obs_v), 32'd0);
        send_bit(1'b1, "ff");
        send_bit(1'b1, "ff");
        settle();
        exp_dv++;
        check("ff_rxdata", 32'(rx_data), 32'hFF);
        check("ff_dvcnt", 32'(dv_cnt), 32'(exp_dv));
        check("ff_secnt", 32'(se_cnt), 32'(exp_se));
        send_eop("ff");

        // Seven unstuffed ones: violation on the seventh strobe
        for (int i = 0; i < 6; i++) send_bit(1'b1, "err");
        strobe_level(line, 1'b0, obs_d, obs_v);
        check("err_7th_valid", 32'(obs_v), 32'd0);
        settle();
        exp_se++;
        check("err_secnt", 32'(se_cnt), 32'(exp_se));
        check("err_dvcnt", 32'(dv_cnt), 32'(exp_dv));
        send_bit(1'b1, "err_after");
        send_eop("err");
        check("err_no_word", 32'(dv_cnt), 32'(exp_dv));

        // Partial word dropped by eop, then a full word
        send_bit(1'b1, "part");
        send_bit(1'b0, "part");
        send_bit(1'b1, "part");
        send_eop("part");
        settle();
        check("part_dvcnt", 32'(dv_cnt), 32'(exp_dv));
        check("part_rx_hold", 32'(rx_data), 32'hFF);
        send_byte(8'h3C, "3c");
        settle();
        exp_dv++;
        check("3c_rxdata", 32'(rx_data), 32'h3C);
        check("3c_dvcnt", 32'(dv_cnt), 32'(exp_dv));

        // Clear during a strobe mid-word drops the bit and the partial word
        send_bit(1'b0, "clr");
        send_bit(1'b1, "clr");
        send_bit(1'b0, "clr");
        @(negedge clk);
        dp_in = 1'b1;
        line  = 1'b1;
        repeat (6) @(negedge clk);
        shift_enable = 1'b1;
        clear        = 1'b1;
        #1;
        check("clr_valid", 32'(bit_valid), 32'd0);
        @(negedge clk);
        shift_enable = 1'b0;
        clear        = 1'b0;
        send_byte(8'h5A, "5a");
        settle();
        exp_dv++;
        check("5a_rxdata", 32'(rx_data), 32'h5A);
        check("5a_dvcnt", 32'(dv_cnt), 32'(exp_dv));
        send_eop("5a");

        // Reset mid-word
        send_bit(1'b1, "rmw");
        send_bit(1'b1, "rmw");
        send_bit(1'b0, "rmw");
        send_bit(1'b1, "rmw");
        send_bit(1'b0, "rmw");
        @(negedge clk);
        n_rst = 1'b0;
        dp_in = 1'b1;
        line  = 1'b1;
        #1;
        check("rmw_rxdata", 32'(rx_data), 32'h00);
        check("rmw_dv", 32'(data_valid), 32'd0);
        check("rmw_se", 32'(stuff_err), 32'd0);
        check("rmw_dorig", 32'(d_orig), 32'd1);
        check("rmw_valid", 32'(bit_valid), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        send_byte(8'h81, "81");
        settle();
        exp_dv++;
        check("81_rxdata", 32'(rx_data), 32'h81);
        check("81_dvcnt", 32'(dv_cnt), 32'(exp_dv));
        check("final_secnt", 32'(se_cnt), 32'(exp_se));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
